// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pc_ctrl encodings, instruction field positions,
// opcode constants and fetch FSM state encodings.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_JUMP = 2'b10,
    PC_ZERO = 2'b11
  } pc_ctrl_e;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RD_MSB     = 11;
  localparam int RD_LSB     = 10;
  localparam int RS_MSB     = 9;
  localparam int RS_LSB     = 8;
  localparam int IMM_MSB    = 7;
  localparam int IMM_LSB    = 0;

  localparam logic [3:0] OP_MOVEB = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_JUMP  = 4'b1010;

  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_REQ  = 2'b01,
    FS_DONE = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with its pc_ctrl next-value mux; also intended
// for reuse by later branch logic.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      ctrl,
  input  logic [7:0]      imm,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_nxt;

  always_comb begin
    pc_nxt = pc;
    if (en) begin
      case (ctrl)
        PC_INC:  pc_nxt = pc + 1'b1;
        PC_JUMP: pc_nxt = PC_W'(imm);
        PC_ZERO: pc_nxt = '0;
        default: pc_nxt = pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= pc_nxt;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch responder: owns PC and IR, runs the imem req/ack handshake.
// Optional ack timeout enabled by defining FETCH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no fetch issued since reset
// REQ     | imem_req high, waiting for imem_ack
// DONE    | IR loaded, en1 high until the next fetch pulse
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_fetch_pulse,
  input  logic               en_pc_pulse,
  input  logic [1:0]         pc_ctrl,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               en1,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [1:0]         rd,
  output logic [1:0]         rs,
  output logic [7:0]         imm,
  output logic               fetch_err
);

  fetch_state_e state, state_nxt;
  logic [PC_W-1:0] fetch_addr;
  logic start_fetch;
  logic ack_take;
  logic tmo;

  assign start_fetch = (state != FS_REQ) && en_fetch_pulse;
  assign ack_take    = (state == FS_REQ) && imem_ack;

  pc_reg #(.PC_W(PC_W)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .en   (en_pc_pulse),
    .ctrl (pc_ctrl),
    .imm  (imm),
    .pc   (pc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FS_IDLE, FS_DONE: if (en_fetch_pulse) state_nxt = FS_REQ;
      FS_REQ:           if (imem_ack || tmo) state_nxt = FS_DONE;
      default:          state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FS_IDLE;
      fetch_addr <= '0;
      ir         <= '0;
    end else begin
      state <= state_nxt;
      // address is captured from the pre-update pc when both pulses coincide
      if (start_fetch) fetch_addr <= pc;
      if (ack_take)    ir <= imem_rdata;
      else if (tmo)    ir <= '0;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CNT_W-1:0] tmo_cnt;

  // down-counter loaded on REQ entry; terminal count after TIMEOUT REQ cycles
  assign tmo = (state == FS_REQ) && !imem_ack && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (start_fetch)                         tmo_cnt <= CNT_W'(TIMEOUT - 1);
      else if (state == FS_REQ && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
      if (tmo) fetch_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo            = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  assign imem_req  = (state == FS_REQ);
  assign en1       = (state == FS_DONE);
  assign imem_addr = fetch_addr;

  assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
  assign rd     = ir[RD_MSB:RD_LSB];
  assign rs     = ir[RS_MSB:RS_LSB];
  assign imm    = ir[IMM_MSB:IMM_LSB];

endmodule
